// File: rtl/instr_mem_sync.sv
// instr_mem_sync: synchronous instruction memory for the IF stage.
// Registered fetch port (1-cycle latency) with stall-hold and flush-to-NOP,
// plus a host boot-load port (valid/ready) and an auto-fill engine that pads
// every word after the last host word with NOP_WORD.
// Optional: `define INSTR_MEM_PARITY_EN adds a stored even-parity bit per word,
// a parity_err output and a force_bad_parity hook.
module instr_mem_sync #(
   parameter int unsigned        ADDR_W   = 6,
   parameter int unsigned        DATA_W   = 32,
   parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(32'h0000_0013)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ADDR_W+1:0]   pc,
   input  logic                fetch_en,
   input  logic                stall,
   input  logic                flush,
   output logic [DATA_W-1:0]   instr_out,
   output logic                instr_valid,
   output logic                misalign,
   input  logic                ld_start,
   input  logic                ld_valid,
   input  logic [DATA_W-1:0]   ld_data,
   input  logic                ld_last,
   output logic                ld_ready,
   output logic                busy,
   output logic                ld_done
`ifdef INSTR_MEM_PARITY_EN
   ,
   output logic                parity_err,
   input  logic                force_bad_parity
`endif
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;
`ifdef INSTR_MEM_PARITY_EN
   localparam int unsigned MEM_W = DATA_W + 1;
`else
   localparam int unsigned MEM_W = DATA_W;
`endif

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_LOAD = 2'd1,
      S_FILL = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   instr_q, instr_d;
   logic                valid_q, valid_d;
   logic                mis_q, mis_d;
   logic                ld_ready_q, ld_ready_d;
   logic                busy_q, busy_d;
   logic                ld_done_q, ld_done_d;
   logic                par_err_q, par_err_d;

   logic [MEM_W-1:0]    mem [DEPTH];
   logic [MEM_W-1:0]    rd_word_c;
   logic                mem_we_c;
   logic [ADDR_W-1:0]   mem_waddr_c;
   logic [MEM_W-1:0]    mem_wdata_c;
   logic [MEM_W-1:0]    host_entry_c;
   logic [MEM_W-1:0]    nop_entry_c;
   logic                last_slot_c;
   logic                host_acc_c;

   // Storage encoding of host and fill words (parity bit on top when enabled).
   always_comb begin
`ifdef INSTR_MEM_PARITY_EN
      host_entry_c = {(^ld_data) ^ force_bad_parity, ld_data};
      nop_entry_c  = {^NOP_WORD, NOP_WORD};
`else
      host_entry_c = ld_data;
      nop_entry_c  = NOP_WORD;
`endif
   end

   assign rd_word_c   = mem[pc[ADDR_W+1:2]];
   assign last_slot_c = (cnt_q == CNT_W'(DEPTH - 1));
   assign host_acc_c  = ld_valid & ld_ready_q;

   // Next-state, fetch outputs and memory write control.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      instr_d     = instr_q;
      valid_d     = valid_q;
      mis_d       = mis_q;
      par_err_d   = par_err_q;
      ld_ready_d  = ld_ready_q;
      busy_d      = busy_q;
      ld_done_d   = 1'b0;
      mem_we_c    = 1'b0;
      mem_waddr_c = cnt_q[ADDR_W-1:0];
      mem_wdata_c = host_entry_c;

      // While loading or filling the fetch port only ever presents NOP.
      if (state_q != S_RUN) begin
         instr_d   = NOP_WORD;
         valid_d   = 1'b0;
         mis_d     = 1'b0;
         par_err_d = 1'b0;
      end

      case (state_q)
         S_RUN: begin
            if (flush) begin
               instr_d   = NOP_WORD;
               valid_d   = 1'b0;
               mis_d     = 1'b0;
               par_err_d = 1'b0;
            end else if (stall) begin
               instr_d = instr_q;
            end else if (fetch_en) begin
               instr_d   = rd_word_c[DATA_W-1:0];
               valid_d   = 1'b1;
               mis_d     = (pc[1:0] != 2'b00);
               par_err_d = ^rd_word_c;
            end else begin
               valid_d = 1'b0;
            end
            if (ld_start) begin
               state_d    = S_LOAD;
               cnt_d      = '0;
               busy_d     = 1'b1;
               ld_ready_d = 1'b1;
            end
         end
         S_LOAD: begin
            if (host_acc_c) begin
               mem_we_c = 1'b1;
               cnt_d    = cnt_q + CNT_W'(1);
               if (last_slot_c) begin
                  state_d    = S_RUN;
                  cnt_d      = '0;
                  busy_d     = 1'b0;
                  ld_ready_d = 1'b0;
                  ld_done_d  = 1'b1;
               end else if (ld_last) begin
                  state_d    = S_FILL;
                  ld_ready_d = 1'b0;
               end
            end
         end
         S_FILL: begin
            mem_we_c    = 1'b1;
            mem_wdata_c = nop_entry_c;
            cnt_d       = cnt_q + CNT_W'(1);
            if (last_slot_c) begin
               state_d    = S_RUN;
               cnt_d      = '0;
               busy_d     = 1'b0;
               ld_ready_d = 1'b0;
               ld_done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_RUN;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_RUN;
         cnt_q      <= '0;
         instr_q    <= NOP_WORD;
         valid_q    <= 1'b0;
         mis_q      <= 1'b0;
         par_err_q  <= 1'b0;
         ld_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         ld_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         instr_q    <= instr_d;
         valid_q    <= valid_d;
         mis_q      <= mis_d;
         par_err_q  <= par_err_d;
         ld_ready_q <= ld_ready_d;
         busy_q     <= busy_d;
         ld_done_q  <= ld_done_d;
      end
   end

   // Memory array write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         mem[mem_waddr_c] <= mem_wdata_c;
      end
   end

   assign instr_out   = instr_q;
   assign instr_valid = valid_q;
   assign misalign    = mis_q;
   assign ld_ready    = ld_ready_q;
   assign busy        = busy_q;
   assign ld_done     = ld_done_q;
`ifdef INSTR_MEM_PARITY_EN
   assign parity_err  = par_err_q;
`else
   logic unused_par_c;
   assign unused_par_c = par_err_q;
`endif

endmodule

// File: tb/tb_instr_mem_sync.sv
// tb_instr_mem_sync: randomized scoreboard bench for instr_mem_sync.
// A word-array reference model predicts each fetch-port output; a monitor on
// the falling edge pops predictions and compares. Load-port control is
// checked inline. Define INSTR_MEM_PARITY_EN to include the parity checks.
module tb_instr_mem_sync;

   localparam int unsigned ADDR_W = 6;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 64;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  pc;
   logic        fetch_en, stall, flush;
   logic [31:0] instr_out;
   logic        instr_valid, misalign;
   logic        ld_start, ld_valid, ld_last;
   logic [31:0] ld_data;
   logic        ld_ready, busy, ld_done;
`ifdef INSTR_MEM_PARITY_EN
   logic        parity_err;
   logic        force_bad_parity;
`endif

   always #5 clk = ~clk;

   instr_mem_sync #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NOP_WORD(NOP)) dut (
      .clk(clk), .rst_n(rst_n), .pc(pc), .fetch_en(fetch_en), .stall(stall),
      .flush(flush), .instr_out(instr_out), .instr_valid(instr_valid),
      .misalign(misalign), .ld_start(ld_start), .ld_valid(ld_valid),
      .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready), .busy(busy),
      .ld_done(ld_done)
`ifdef INSTR_MEM_PARITY_EN
      , .parity_err(parity_err), .force_bad_parity(force_bad_parity)
`endif
   );

   typedef struct {
      logic [31:0] instr;
      logic        valid;
      logic        mis;
      logic        par;
      logic        chk_instr;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        cur;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] ref_mem [DEPTH];
   bit          known   [DEPTH];
   bit          bad_par [DEPTH];
   logic [31:0] ld_words[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare the DUT fetch port against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("instr_valid", 32'(instr_valid), 32'(e.valid));
            if (e.chk_instr) chk("instr_out", instr_out, e.instr);
            if (e.valid) chk("misalign", 32'(misalign), 32'(e.mis));
`ifdef INSTR_MEM_PARITY_EN
            if (e.chk_instr) chk("parity_err", 32'(parity_err), 32'(e.par));
`endif
         end
      end
   end

   // Reference behaviour of the fetch port for one RUN cycle.
   task automatic model_run(input logic fe, input logic [7:0] a, input logic st, input logic fl);
      int idx;
      idx = int'(a[7:2]);
      if (fl) cur = '{NOP, 1'b0, 1'b0, 1'b0, 1'b1};
      else if (st) begin end
      else if (fe) begin
         cur.instr     = ref_mem[idx];
         cur.chk_instr = known[idx];
         cur.valid     = 1'b1;
         cur.mis       = (a[1:0] != 2'b00);
         cur.par       = bad_par[idx];
      end else cur.valid = 1'b0;
   endtask

   task automatic run_cycle(input logic fe, input logic [7:0] a, input logic st,
                            input logic fl, input logic ls);
      fetch_en = fe; pc = a; stall = st; flush = fl; ld_start = ls;
      model_run(fe, a, st, fl);
      @(posedge clk);
      sb_q.push_back(cur);
      #1;
      ld_start = 1'b0;
   endtask

   // Boot-load ld_words[0..n-1]; exp_busy < 0 skips the busy-length check.
   task automatic do_load(input int n, input bit use_last, input bit gaps,
                          input bit bad_first, input int exp_busy);
      int i = 0, cyc = 0, busy_cyc = 1;
      bit fin = 0, acc;
      run_cycle(1'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1);
      chk("ld_ready_start", 32'(ld_ready), 32'd1);
      chk("busy_start", 32'(busy), 32'd1);
      while (!fin && cyc < 400) begin
         fetch_en = 1'($urandom); stall = 1'($urandom); flush = 1'($urandom);
         pc = 8'($urandom);
         ld_start = (cyc == 5) && busy;
         ld_valid = (gaps ? (cyc % 2 == 0) : 1'b1) && (i < n);
         ld_data  = (i < n) ? ld_words[i] : 32'h0;
         ld_last  = use_last && (i == n - 1);
`ifdef INSTR_MEM_PARITY_EN
         force_bad_parity = bad_first && (i == 0);
`endif
         acc = ld_valid && ld_ready;
         @(posedge clk);
         cur = '{NOP, 1'b0, 1'b0, 1'b0, 1'b1};
         sb_q.push_back(cur);
         if (acc) begin
            ref_mem[i] = ld_data; known[i] = 1; bad_par[i] = bad_first && (i == 0);
            i++;
         end
         #1;
         cyc++;
         if (ld_done) fin = 1;
         else if (busy) busy_cyc++;
         if (acc && i == DEPTH) begin
            chk("done_after_full", 32'(ld_done), 32'd1);
            chk("ld_ready_full", 32'(ld_ready), 32'd0);
         end
         if (busy && use_last && i == n) chk("ld_ready_fill", 32'(ld_ready), 32'd0);
      end
      ld_start = 0; ld_valid = 0; ld_last = 0;
`ifdef INSTR_MEM_PARITY_EN
      force_bad_parity = 0;
`endif
      if (!fin) begin
         n_cmp++; n_bad++;
         $display("FAIL load_timeout: got no ld_done expected ld_done within 400 cycles");
      end
      if (exp_busy >= 0) chk("busy_cycles", 32'(busy_cyc), 32'(exp_busy));
      chk("accepted", 32'(i), 32'((use_last && n < DEPTH) ? n : DEPTH));
      chk("busy_end", 32'(busy), 32'd0);
      chk("ld_ready_end", 32'(ld_ready), 32'd0);
      if (use_last) for (int k = i; k < DEPTH; k++) begin
         ref_mem[k] = NOP; known[k] = 1; bad_par[k] = 0;
      end
      run_cycle(1'b0, 8'h0, 1'b0, 1'b0, 1'b0);
      chk("ld_done_pulse", 32'(ld_done), 32'd0);
   endtask

   task automatic fetch_all();
      for (int k = 0; k < DEPTH; k++) run_cycle(1'b1, 8'(k * 4), 1'b0, 1'b0, 1'b0);
   endtask

   task automatic random_run(input int cycles);
      for (int k = 0; k < cycles; k++)
         run_cycle(1'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 7) == 0), 1'b0);
   endtask

   initial begin
      int n;
      rst_n = 0; pc = 0; fetch_en = 0; stall = 0; flush = 0;
      ld_start = 0; ld_valid = 0; ld_last = 0; ld_data = 0;
`ifdef INSTR_MEM_PARITY_EN
      force_bad_parity = 0;
`endif
      for (int k = 0; k < DEPTH; k++) begin known[k] = 0; bad_par[k] = 0; ref_mem[k] = 0; end
      cur = '{NOP, 1'b0, 1'b0, 1'b0, 1'b1};
      #12;
      chk("rst_instr_out", instr_out, NOP);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_misalign", 32'(misalign), 32'd0);
      chk("rst_ld_ready", 32'(ld_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ld_done", 32'(ld_done), 32'd0);
      rst_n = 1;
      @(posedge clk); #1;

      // Idle, then a fetch of unloaded memory.
      run_cycle(1'b0, 8'h0, 1'b0, 1'b0, 1'b0);
      run_cycle(1'b1, 8'h0, 1'b0, 1'b0, 1'b0);

      // Three-word program with ld_last, then fill.
      ld_words = '{32'h0000_3f37, 32'h0200_0fe7, 32'h01c0_2623};
      do_load(3, 1, 0, 0, 64);
      for (int k = 0; k < 4; k++) run_cycle(1'b1, 8'(k * 4), 1'b0, 1'b0, 1'b0);

      // Stall hold then flush overriding stall.
      run_cycle(1'b1, 8'd8, 1'b0, 1'b0, 1'b0);
      repeat (3) run_cycle(1'b1, 8'd12, 1'b1, 1'b0, 1'b0);
      run_cycle(1'b1, 8'd12, 1'b1, 1'b1, 1'b0);

      // Full 64-word load with valid gaps and no ld_last.
      ld_words.delete();
      for (int k = 0; k < DEPTH; k++) ld_words.push_back($urandom);
      do_load(DEPTH, 0, 1, 0, 127);
      fetch_all();
      run_cycle(1'b1, 8'd6, 1'b0, 1'b0, 1'b0);

      random_run(300);

      // Random-length program, then readback and more random traffic.
      n = $urandom_range(1, DEPTH);
      ld_words.delete();
      for (int k = 0; k < n; k++) ld_words.push_back($urandom);
      do_load(n, 1, 0, 0, 64);
      fetch_all();
      random_run(200);

`ifdef INSTR_MEM_PARITY_EN
      ld_words = '{32'h1234_5678};
      do_load(1, 1, 0, 1, 64);
      run_cycle(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
      run_cycle(1'b1, 8'd4, 1'b0, 1'b0, 1'b0);
`endif

      fetch_en = 0;
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
- Parametrised, synchronous instruction memory for the pipelined RISC-V core. Replaces the hard-coded combinational program store.
- Registered fetch output with 1-cycle latency, plus stall-hold and flush-to-NOP for the IF stage.
- Host boot-load port with valid/ready handshake writes a program at run time. An auto-fill engine pads all unwritten words with NOP.

Parameters:
- ADDR_W, 6: word-address width; depth = 2**ADDR_W words.
- DATA_W, 32: instruction width.
- NOP_WORD, 32'h0000_0013: addi x0,x0,0; used for flush, fill and out-of-load output.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc  in  ADDR_W+2  byte address of fetch; word index = pc[ADDR_W+1:2].
- fetch_en  in  1  request a fetch this cycle.
- stall  in  1  hold instr_out/instr_valid unchanged.
- flush  in  1  replace next output with NOP_WORD.
- instr_out  out  DATA_W  fetched instruction.
- instr_valid  out  1  instr_out holds a real fetch.
- misalign  out  1  registered; pc[1:0]!=0 on the captured fetch.
- ld_start  in  1  pulse; begin a program load at word 0.
- ld_valid  in  1  host word valid.
- ld_data  in  DATA_W  host word.
- ld_last  in  1  qualifies final host word.
- ld_ready  out  1  block accepts ld_data.
- busy  out  1  load or fill in progress.
- ld_done  out  1  one-cycle pulse when fill completes.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: instr_out=NOP_WORD, instr_valid=0, misalign=0, ld_ready=0, busy=0, ld_done=0.
  - Internals: state=S_RUN, load counter=0.
  - Memory array contents are not reset.
- States: S_RUN, S_LOAD, S_FILL.
- S_RUN:
  - Priority each cycle: flush > stall > fetch_en.
  - flush: next instr_out=NOP_WORD, instr_valid=0, misalign=0.
  - stall (no flush): all fetch outputs hold.
  - fetch_en: next instr_out=mem[pc word index], instr_valid=1, misalign=(pc[1:0]!=0). The word is still read when misaligned.
  - Otherwise: instr_valid=0, instr_out holds.
  - ld_start: go to S_LOAD, counter=0, busy=1, ld_ready=1 from the next cycle.
- S_LOAD:
  - A word is accepted when ld_valid&&ld_ready: mem[counter]=ld_data, counter++.
  - Accepted word with ld_last:
    - counter < depth-1 after the write: go to S_FILL.
    - Word was at depth-1: go straight to done.
  - Counter reaching depth without ld_last: the last slot accepts, then go to done; further host words are ignored (ld_ready=0).
  - Fetch outputs: instr_out=NOP_WORD, instr_valid=0, regardless of fetch_en. stall and flush are ignored.
  - ld_start is ignored while busy.
- S_FILL:
  - ld_ready=0.
  - Writes NOP_WORD to mem[counter] once per cycle, counter++, up to and including depth-1.
- Done:
  - Next cycle: state=S_RUN, busy=0, ld_ready=0, ld_done=1 for exactly one cycle.
- Simultaneous ld_start and fetch_en in S_RUN: the fetch completes this cycle; the load begins next.
- Counter width is ADDR_W+1 so depth-1 is detected without wrap.
- Reset mid-load: returns to S_RUN; partial contents are retained and unspecified beyond the written words.
- Read latency is 1 cycle. Memory writes take effect for any fetch issued the cycle after.

Optional Feature:
- Macro INSTR_MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed on write (host or fill).
  - Adds output port parity_err (1 bit, reset 0), registered with instr_out. parity_err=1 when a fetched word's stored parity mismatches its data.
  - Testbench hook: force_bad_parity input (1 bit) inverts the stored bit on host writes.
- Undefined: no extra storage bit and no ports; behaviour otherwise identical.

Test Plan:
- Reset then fetch_en=1, pc=0 with no load: instr_valid=1 next cycle. instr_out before the first fetch is 32'h0000_0013.
- ld_start, then 3 words 32'h0000_3f37, 32'h0200_0fe7, 32'h01c0_2623 with ld_last on the third:
  - busy stays high for 3 + 61 fill cycles, then ld_done pulses once.
  - Fetching pc=0,4,8,12 returns the 3 words, then 32'h0000_0013.
- After load, fetch pc=8 with stall=1 for 3 cycles: instr_out stays 32'h01c0_2623, instr_valid=1. Then flush=1 with stall=1: instr_out=NOP_WORD, instr_valid=0.
- Host drives ld_valid with ld_ready gaps (toggle ld_valid every other cycle) for 64 words, no ld_last: all 64 are written, ld_ready=0 after the 64th, ld_done pulses, and no fill state is entered.
- Fetch pc=6: misalign=1, instr_out=mem[1].
- With INSTR_MEM_PARITY_EN: load one word with force_bad_parity=1, fetch it: parity_err=1. Fetch a filled NOP: parity_err=0.
